cu_muldiv: RTL and testbench
============================

# cu_muldiv

Multi-cycle RV32M multiply/divide execution unit that sits beside the EX-stage control unit and shares its decode inputs and register-file read data. It recognises M-extension R-type instructions, stalls the pipeline through the existing hold mechanism while it iterates, then issues a single register write-back. Operand width is parametrised. An optional single-cycle multiplier can be compiled in.

## Interface
- XLEN, 32: operand/result width; must be even and ≥ 8
- CNT_W, $clog2(XLEN)+1: iteration counter width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode_i  in  7  instruction opcode from ID/EX
- funct3_i  in  3  instruction funct3
- funct7_i  in  7  instruction funct7
- reg1_rd_data_i  in  XLEN  rs1 value
- reg2_rd_data_i  in  XLEN  rs2 value
- reg_wr_addr_i  in  5  rd address
- flush_i  in  1  abort the in-flight operation; no write-back
- hold_flag_o  out  3  `HOLD_ID_EX` while busy, else `HOLD_NONE`
- busy_o  out  1  high in START/CALC
- reg_wr_en_o  out  1  one-cycle write strobe
- reg_wr_addr_o  out  5  latched rd
- reg_wr_data_o  out  XLEN  result

## Operation
- Match condition: opcode_i == 7'b0110011 and funct7_i == 7'b0000001. funct3 encodings: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On a match, assert hold_flag_o combinationally in the same cycle.
  - Latch operands, funct3, rd and operand signs.
  - Convert signed operands to magnitudes.
  - Next state: CALC, or DONE for the short cases.
- Short cases, taking DONE on the next cycle:
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = −1): DIV result = rs1; REM result = 0.
  - Any multiply when MULDIV_FAST_MUL_EN is defined.
- CALC:
  - One bit per cycle: shift-add multiply or restoring divide into a 2·XLEN accumulator.
  - Counter runs from XLEN−1 down to 0; the transition to DONE occurs when it reaches 0.
- DONE:
  - Apply sign correction. Product is negated if the operand signs differ (MULHSU treats rs2 as unsigned). Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Select the result: MUL → low XLEN bits; MULH/MULHSU/MULHU → high XLEN bits; DIV/DIVU → quotient; REM/REMU → remainder.
  - Pulse reg_wr_en_o; hold_flag_o = `HOLD_NONE`; next state IDLE.
  - The same instruction is still present on the inputs during DONE and must not retrigger.
- Register x0 as rd: the write strobe is still issued; the register file discards it.
- flush_i high in any state: next state IDLE, no write-back, hold released in the following cycle. flush_i takes priority over a new match and over DONE.
- All other instructions: outputs stay idle and the unit has no effect.

## Timing
- Reset values: state IDLE; accumulator, counter and latched fields 0; reg_wr_en_o 0; reg_wr_data_o 0; reg_wr_addr_o 0; busy_o 0; hold_flag_o `HOLD_NONE`.
- Iterative path (match seen in cycle 0):
  - Cycles 0..XLEN: hold asserted.
  - Cycle XLEN+1: DONE, write strobe.
  - Pipeline stall is XLEN+1 cycles.
- Short path: hold in cycle 0, DONE in cycle 1.
- reg_wr_data_o and reg_wr_addr_o are valid only while reg_wr_en_o is high. They are registered and hold their value otherwise.
- Back-to-back M instructions: the second is matched in the cycle after DONE, with no bubble beyond the pipeline advance.
- Reset asserted mid-CALC: all state clears immediately; no write occurs.

## Configuration
- MULDIV_FAST_MUL_EN:
  - Defined: all four multiply ops compute a full 2·XLEN product with one combinational multiplier in the IDLE cycle and register it. Latency is 1 cycle of hold followed by DONE. Divide is unchanged.
  - Undefined: multiplies use the iterative path (XLEN+1 hold cycles) and no multiplier is inferred.

## Test plan
- MUL: rs1 = 7, rs2 = −3 → write 0xFFFFFFEB after exactly 33 hold cycles (1 hold cycle with FAST_MUL), rd preserved.
- MULH: 0x80000000 × 0x80000000 → 0x40000000. MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU: −1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV: −7 / 2 → 0xFFFFFFFD. REM: −7 % 2 → 0xFFFFFFFF. DIVU: 100 / 7 → 14. REMU: 100 % 7 → 2.
- Divide by zero: DIV 5 / 0 → 0xFFFFFFFF and REM 5 % 0 → 5, each with exactly 1 hold cycle. Overflow: DIV 0x80000000 / −1 → 0x80000000; REM of the same operands → 0.
- flush_i pulsed at CALC cycle 10 → no reg_wr_en_o pulse, hold drops the next cycle, and a following ADD passes through unaffected.
- rst_n dropped mid-CALC, then released, then MULHU issued → clean result with no stale write. Two DIVs back-to-back → two writes, each exactly one cycle wide.

Source files
------------

// File: rtl/cu_muldiv.sv
// RV32M multiply/divide unit: stalls ID/EX while a shift-add multiply or
// restoring divide iterates, then issues one write-back. Option: MULDIV_FAST_MUL_EN.
module cu_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] reg1_rd_data_i,
  input  logic [XLEN-1:0] reg2_rd_data_i,
  input  logic [4:0]      reg_wr_addr_i,
  input  logic            flush_i,
  output logic [2:0]      hold_flag_o,
  output logic            busy_o,
  output logic            reg_wr_en_o,
  output logic [4:0]      reg_wr_addr_o,
  output logic [XLEN-1:0] reg_wr_data_o
);
  localparam logic [2:0] HOLD_NONE  = 3'b000;
  localparam logic [2:0] HOLD_ID_EX = 3'b011;
  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] F7_M       = 7'b0000001;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;
  state_t r_state, w_next;

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic              r_neg1, r_neg2, r_fix;
  logic [XLEN-1:0]   r_wr_data;
  logic [4:0]        r_wr_addr;

  logic              w_match, w_start, w_is_div, w_sgn1, w_sgn2, w_neg1, w_neg2;
  logic              w_div0, w_ovf, w_short;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_op_init, w_quot, w_rem, w_result;
  logic [2*XLEN-1:0] w_acc_init, w_mul_step, w_div_step, w_prod;
  logic [XLEN:0]     w_mul_sum, w_div_diff;

  assign w_match  = (opcode_i == OP_R) && (funct7_i == F7_M);
  assign w_start  = (r_state == S_IDLE) && w_match && !flush_i;
  assign w_is_div = funct3_i[2];
  // Signed rs1: MUL, MULH, MULHSU, DIV, REM; signed rs2: same minus MULHSU
  assign w_sgn1   = (funct3_i != 3'd3) && (funct3_i != 3'd5) && (funct3_i != 3'd7);
  assign w_sgn2   = w_sgn1 && (funct3_i != 3'd2);
  assign w_neg1   = w_sgn1 && reg1_rd_data_i[XLEN-1];
  assign w_neg2   = w_sgn2 && reg2_rd_data_i[XLEN-1];
  assign w_mag1   = w_neg1 ? (~reg1_rd_data_i + 1'b1) : reg1_rd_data_i;
  assign w_mag2   = w_neg2 ? (~reg2_rd_data_i + 1'b1) : reg2_rd_data_i;
  assign w_div0   = w_is_div && (reg2_rd_data_i == '0);
  assign w_ovf    = w_is_div && w_sgn2 && (reg1_rd_data_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (reg2_rd_data_i == '1);
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
  assign w_short     = w_div0 || w_ovf || !w_is_div;
`else
  assign w_short     = w_div0 || w_ovf;
`endif

  // Short cases preload the final {rem, quot} and bypass sign correction
  always_comb begin
    w_acc_init = {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
    w_op_init  = w_is_div ? w_mag2 : w_mag1;
    if (w_div0)
      w_acc_init = {reg1_rd_data_i, {XLEN{1'b1}}};
    else if (w_ovf)
      w_acc_init = {{XLEN{1'b0}}, reg1_rd_data_i};
`ifdef MULDIV_FAST_MUL_EN
    else if (!w_is_div)
      w_acc_init = w_fast_prod;
`endif
  end

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_op};
  assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
  assign w_div_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_op};
  assign w_div_step = w_div_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                       : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prod = (r_fix && (r_neg1 ^ r_neg2)) ? (~r_acc + 1'b1) : r_acc;
  assign w_quot = (r_fix && (r_neg1 ^ r_neg2)) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = (r_fix && r_neg1) ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_result = w_prod[XLEN-1:0];
    case (r_f3)
      3'd1, 3'd2, 3'd3: w_result = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_result = w_quot;
      3'd6, 3'd7:       w_result = w_rem;
      default:          w_result = w_prod[XLEN-1:0];
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = w_short ? S_DONE : S_CALC;
      S_CALC: if (flush_i) w_next = S_IDLE;
              else if (r_cnt == '0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_op      <= '0;
      r_cnt     <= '0;
      r_f3      <= '0;
      r_rd      <= '0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      r_fix     <= 1'b0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_acc  <= w_acc_init;
          r_op   <= w_op_init;
          r_cnt  <= CNT_W'(XLEN-1);
          r_f3   <= funct3_i;
          r_rd   <= reg_wr_addr_i;
          r_neg1 <= w_neg1;
          r_neg2 <= w_neg2;
          r_fix  <= !(w_div0 || w_ovf);
        end
        S_CALC: begin
          r_acc <= r_f3[2] ? w_div_step : w_mul_step;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DONE: if (!flush_i) begin
          r_wr_data <= w_result;
          r_wr_addr <= r_rd;
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = w_start || (r_state == S_CALC);
  assign hold_flag_o   = busy_o ? HOLD_ID_EX : HOLD_NONE;
  assign reg_wr_en_o   = (r_state == S_DONE) && !flush_i;
  assign reg_wr_data_o = reg_wr_en_o ? w_result : r_wr_data;
  assign reg_wr_addr_o = reg_wr_en_o ? r_rd : r_wr_addr;
endmodule

// File: tb/tb_cu_muldiv.sv
// Self-checking bench for cu_muldiv: directed RV32M vectors, random operands
// against a 64-bit arithmetic model, flush, mid-operation reset, back-to-back.
module tb_cu_muldiv;
  localparam int XLEN = 32;
  localparam logic [2:0] HOLD_NONE  = 3'b000;
  localparam logic [2:0] HOLD_ID_EX = 3'b011;

  logic            clk, rst_n, flush_i;
  logic [6:0]      opcode_i, funct7_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] reg1_rd_data_i, reg2_rd_data_i;
  logic [4:0]      reg_wr_addr_i;
  logic [2:0]      hold_flag_o;
  logic            busy_o, reg_wr_en_o;
  logic [4:0]      reg_wr_addr_o;
  logic [XLEN-1:0] reg_wr_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  cu_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .funct7_i(funct7_i), .reg1_rd_data_i(reg1_rd_data_i), .reg2_rd_data_i(reg2_rd_data_i),
    .reg_wr_addr_i(reg_wr_addr_i), .flush_i(flush_i), .hold_flag_o(hold_flag_o),
    .busy_o(busy_o), .reg_wr_en_o(reg_wr_en_o), .reg_wr_addr_o(reg_wr_addr_o),
    .reg_wr_data_o(reg_wr_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_holds(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    opcode_i = 7'b0110011; funct7_i = 7'b0000001; funct3_i = f3;
    reg1_rd_data_i = a; reg2_rd_data_i = b; reg_wr_addr_i = rd;
  endtask

  task automatic drive_other(input logic [6:0] op);
    opcode_i = op; funct7_i = 7'd0; funct3_i = 3'd0;
    reg1_rd_data_i = 32'd11; reg2_rd_data_i = 32'd22; reg_wr_addr_i = 5'd7;
  endtask

  // Presents one M instruction and holds it until the unit releases the stall,
  // then advances one cycle. Entered and left at posedge+1.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int holds, output int wrs,
                        output logic [31:0] data, output logic [4:0] addr);
    bit fin;
    drive_m(f3, a, b, rd);
    holds = 0; wrs = 0; data = '0; addr = '0; fin = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (reg_wr_en_o) begin wrs++; data = reg_wr_data_o; addr = reg_wr_addr_o; end
      if (hold_flag_o === HOLD_ID_EX) holds++; else fin = 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush_i = 1'b0; drive_other(7'b0010011);
    #12;
    n_checks++; if (hold_flag_o !== HOLD_NONE) begin n_fail++; $display("FAIL reset_hold got=%0h want=%0h", hold_flag_o, HOLD_NONE); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    n_checks++; if (reg_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b want=0", reg_wr_en_o); end
    n_checks++; if (reg_wr_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h want=0", reg_wr_data_o); end
    n_checks++; if (reg_wr_addr_o !== 5'd0) begin n_fail++; $display("FAIL reset_addr got=%0d want=0", reg_wr_addr_o); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [2:0]  f3s [12];
    logic [31:0] as [12], bs [12], want [12];
    int holds, wrs; logic [31:0] data; logic [4:0] addr, rd;
    f3s  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    as   = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
             32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    bs   = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    want = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
             32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    for (int i = 0; i < 12; i++) begin
      rd = 5'(i + 1);
      run_op(f3s[i], as[i], bs[i], rd, holds, wrs, data, addr);
      n_checks++; if (data !== want[i]) begin n_fail++; $display("FAIL dir%0d_data got=%h want=%h", i, data, want[i]); end
      n_checks++; if (holds != exp_holds(f3s[i], as[i], bs[i])) begin n_fail++; $display("FAIL dir%0d_holds got=%0d want=%0d", i, holds, exp_holds(f3s[i], as[i], bs[i])); end
      n_checks++; if (wrs != 1) begin n_fail++; $display("FAIL dir%0d_writes got=%0d want=1", i, wrs); end
      n_checks++; if (addr !== rd) begin n_fail++; $display("FAIL dir%0d_rd got=%0d want=%0d", i, addr, rd); end
      drive_other(7'b0010011);
      @(negedge clk);
      n_checks++; if (hold_flag_o !== HOLD_NONE || reg_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL dir%0d_retrigger hold=%0h wr_en=%b want hold=0 wr_en=0", i, hold_flag_o, reg_wr_en_o); end
      n_checks++; if (reg_wr_data_o !== want[i]) begin n_fail++; $display("FAIL dir%0d_data_hold got=%h want=%h", i, reg_wr_data_o, want[i]); end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    int holds, wrs; logic [31:0] data, a, b, w; logic [4:0] addr, rd; logic [2:0] f3;
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7)); a = pick(); b = pick(); rd = 5'($urandom_range(0, 31));
      w = model(f3, a, b);
      run_op(f3, a, b, rd, holds, wrs, data, addr);
      n_checks++; if (data !== w || wrs != 1 || addr !== rd || holds != exp_holds(f3, a, b)) begin
        n_fail++;
        $display("FAIL rnd%0d f3=%0d a=%h b=%h data got=%h want=%h writes=%0d holds got=%0d want=%0d rd got=%0d want=%0d",
                 i, f3, a, b, data, w, wrs, holds, exp_holds(f3, a, b), addr, rd);
      end
      drive_other(7'b0010011);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush;
    int wrs, bad;
    wrs = 0; bad = 0;
    drive_m(3'd4, 32'd1000, 32'd3, 5'd9);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); if (reg_wr_en_o) wrs++;
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    if (reg_wr_en_o) wrs++;
    n_checks++; if (hold_flag_o !== HOLD_ID_EX) begin n_fail++; $display("FAIL flush_cycle_hold got=%0h want=%0h", hold_flag_o, HOLD_ID_EX); end
    @(posedge clk); #1;
    flush_i = 1'b0; drive_other(7'b0110011);
    @(negedge clk);
    n_checks++; if (hold_flag_o !== HOLD_NONE || busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_release hold=%0h busy=%b want hold=0 busy=0", hold_flag_o, busy_o); end
    for (int c = 0; c < 40; c++) begin
      if (reg_wr_en_o) wrs++;
      if (hold_flag_o !== HOLD_NONE) bad++;
      @(posedge clk); #1; @(negedge clk);
    end
    n_checks++; if (wrs != 0) begin n_fail++; $display("FAIL flush_no_write got=%0d want=0", wrs); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL flush_add_passthrough held_cycles got=%0d want=0", bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int holds, wrs; logic [31:0] data; logic [4:0] addr;
    drive_m(3'd0, 32'd123, 32'd456, 5'd5);
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; end
    drive_other(7'b0010011);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0 || reg_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL midrst_clear busy=%b wr_en=%b want 0 0", busy_o, reg_wr_en_o); end
    n_checks++; if (reg_wr_data_o !== 32'd0) begin n_fail++; $display("FAIL midrst_data got=%h want=0", reg_wr_data_o); end
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, holds, wrs, data, addr);
    n_checks++; if (data !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL midrst_mulhu_data got=%h want=fffffffe", data); end
    n_checks++; if (wrs != 1 || addr !== 5'd17) begin n_fail++; $display("FAIL midrst_mulhu_write writes=%0d rd=%0d want 1 17", wrs, addr); end
    n_checks++; if (holds != exp_holds(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF)) begin n_fail++; $display("FAIL midrst_mulhu_holds got=%0d want=%0d", holds, exp_holds(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF)); end
    drive_other(7'b0010011);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int h1, w1, h2, w2; logic [31:0] d1, d2; logic [4:0] a1, a2;
    run_op(3'd4, 32'd100, 32'd7, 5'd3, h1, w1, d1, a1);
    run_op(3'd4, 32'hFFFFFF9C, 32'd7, 5'd4, h2, w2, d2, a2);
    drive_other(7'b0010011);
    n_checks++; if (d1 !== 32'd14 || w1 != 1 || a1 !== 5'd3) begin n_fail++; $display("FAIL b2b_first data=%h writes=%0d rd=%0d want 0000000e 1 3", d1, w1, a1); end
    n_checks++; if (d2 !== 32'hFFFFFFF2 || w2 != 1 || a2 !== 5'd4) begin n_fail++; $display("FAIL b2b_second data=%h writes=%0d rd=%0d want fffffff2 1 4", d2, w2, a2); end
    n_checks++; if (h1 != XLEN + 1 || h2 != XLEN + 1) begin n_fail++; $display("FAIL b2b_holds got=%0d,%0d want=%0d", h1, h2, XLEN + 1); end
    @(negedge clk);
    n_checks++; if (reg_wr_en_o !== 1'b0 || hold_flag_o !== HOLD_NONE) begin n_fail++; $display("FAIL b2b_idle wr_en=%b hold=%0h want 0 0", reg_wr_en_o, hold_flag_o); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
